stream_decimate_relay: RTL

Parametrised token relay actor for the visual-saliency pyramid. It consumes pixels on an In1 token port and optionally discards them by a 2-D decimation pattern (keep every DECIM_X-th column of every DECIM_Y-th row). Kept pixels are buffered in a DEPTH-entry FIFO and emitted on an Out1 token port. It replaces fixed single-token pass-through actors between pyramid levels, decoupling producer and consumer and halving or quartering resolution in-line.

---
 rtl/stream_decimate_relay_pkg.sv | 12 +
 rtl/stream_decimate_relay_fifo.sv | 49 ++++
 rtl/stream_decimate_relay.sv | 99 +++++++++
 3 files changed

// File: rtl/stream_decimate_relay_pkg.sv
// stream_decimate_relay_pkg: token-port constants and sizing helpers shared by the relay.
package stream_decimate_relay_pkg;
    localparam int TOKEN_W = 16;
    localparam int COUNT_W = 16;
    typedef logic [COUNT_W-1:0] count_t;
    localparam count_t TOKEN_COUNT = 16'h1;

    // Index width that never collapses to zero for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/stream_decimate_relay_fifo.sv
// stream_decimate_relay_fifo: DEPTH-entry token buffer with occupancy-based full/empty.
module stream_decimate_relay_fifo
    import stream_decimate_relay_pkg::*;
#(
    parameter int DATA_W = TOKEN_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int PW = idx_w(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [OW-1:0]     occ;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push != pop)
                occ <= push ? occ + OW'(1) : occ - OW'(1);
        end
    end

    // Head is read combinationally so a pop sees the entry before a same-cycle overwrite.
    assign rdata = mem[rd_ptr];
    assign full  = occ == OW'(DEPTH);
    assign empty = occ == '0;
endmodule

// File: rtl/stream_decimate_relay.sv
// stream_decimate_relay: token relay that keeps every DECIM_X-th column of every
// DECIM_Y-th row and buffers kept tokens in a small FIFO.
module stream_decimate_relay
    import stream_decimate_relay_pkg::*;
#(
    parameter int DATA_W  = TOKEN_W,
    parameter int DEPTH   = 4,
    parameter int IMG_W   = 512,
    parameter int IMG_H   = 512,
    parameter int DECIM_X = 2,
    parameter int DECIM_Y = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] In1_DATA,
    input  logic              In1_SEND,
    output logic              In1_ACK,
    input  logic [15:0]       In1_COUNT,
    output logic [DATA_W-1:0] Out1_DATA,
    output logic              Out1_SEND,
    input  logic              Out1_RDY,
    input  logic              Out1_ACK,
    output logic [15:0]       Out1_COUNT,
    input  logic              BYPASS,
    output logic              FRAME_END
);
    localparam int CW = idx_w(IMG_W);
    localparam int RW = idx_w(IMG_H);
    localparam int XW = idx_w(DECIM_X);
    localparam int YW = idx_w(DECIM_Y);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(DECIM_X - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(DECIM_Y - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          keep;
    logic          consume;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          col_end;
    logic          row_end;
    logic          frame_end;
    logic          unused_ok;

    assign unused_ok = ^{In1_COUNT, Out1_ACK};

    assign col_end = col == COL_LAST;
    assign row_end = row == ROW_LAST;
    assign keep    = BYPASS | (cx == '0 && cy == '0);
    assign pop     = Out1_RDY & ~empty;
    // Dropped tokens never need space, so they are acked even when the buffer is full.
    assign In1_ACK = In1_SEND & ~RESET & (~keep | ~full | pop);
    assign consume = In1_SEND & In1_ACK;
    assign push    = consume & keep;

    assign Out1_SEND  = pop;
    assign Out1_COUNT = TOKEN_COUNT;
    assign FRAME_END  = frame_end;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            col       <= '0;
            row       <= '0;
            cx        <= '0;
            cy        <= '0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= consume & col_end & row_end;
            if (consume) begin
                col <= col_end ? '0 : col + CW'(1);
                cx  <= (col_end || cx == X_LAST) ? '0 : cx + XW'(1);
                if (col_end) begin
                    row <= row_end ? '0 : row + RW'(1);
                    cy  <= (row_end || cy == Y_LAST) ? '0 : cy + YW'(1);
                end
            end
        end
    end

    stream_decimate_relay_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk  (CLK),
        .rst  (RESET),
        .push (push),
        .pop  (pop),
        .wdata(In1_DATA),
        .rdata(Out1_DATA),
        .full (full),
        .empty(empty)
    );
endmodule
